// File: rtl/matrix_pkg.sv
// matrix_pkg -- geometry constants and pixel indexing shared by the LED
// matrix driver and the game core that produces its frames.
//   MATRIX_ROWS / MATRIX_COLS : panel size (8x8)
//   pix(r,c)                  : bit position of pixel (r,c) in a frame word
package matrix_pkg;

   localparam int MATRIX_ROWS = 8;
   localparam int MATRIX_COLS = 8;
   localparam int ROW_W       = $clog2(MATRIX_ROWS);
   localparam int COL_W       = $clog2(MATRIX_COLS);
   localparam int PIX_W       = ROW_W + COL_W;

   // 8*r + c; the column count is a power of two, so this is a concatenation
   function automatic logic [PIX_W-1:0] pix(input logic [ROW_W-1:0] r,
                                            input logic [COL_W-1:0] c);
      return {r, c};
   endfunction

endpackage

// File: rtl/scan_divider.sv
// scan_divider -- modulo-SCAN_DIV cycle counter that paces the row slots.
//   clk, reset : clock, asynchronous active-low reset
//   en         : count enable (counter holds while low)
//   div_cnt    : current count, 0..SCAN_DIV-1
//   tick       : high in the last cycle of a slot (count wraps at the edge)
module scan_divider #(
   parameter int SCAN_DIV = 1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        en,
   output logic [$clog2(SCAN_DIV)-1:0] div_cnt,
   output logic                        tick
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = en && (cnt_q == LAST);
      cnt_d = cnt_q;
      if (en) cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign div_cnt = cnt_q;

endmodule

// File: rtl/matrix_scan.sv
// matrix_scan -- double-buffered row-multiplexing driver for the 8x8 LED
// matrix. Frames written with `load` are held pending and swapped into the
// display buffer only at the row 7 -> 0 wrap, so a scan never tears.
//   clk, reset  : clock, asynchronous active-low reset
//   matrix,load : frame word (bit 8*r+c = pixel r,c) and its capture strobe
//   row         : one-hot row select, active-high
//   col         : column drive, active-low
//   scan_row    : row currently scanned
//   frame_start : one-cycle pulse on the first cycle of row 0
//   busy        : a pending frame is waiting for the swap
// Build option: MATRIX_BLANK_EN adds BLANK_CYCLES of dark time at the start
// of every row slot (anti-ghosting).
module matrix_scan
   import matrix_pkg::*;
#(
   parameter int SCAN_DIV     = 1024,
   parameter int BLANK_CYCLES = 16
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic [MATRIX_ROWS*MATRIX_COLS-1:0]   matrix,
   input  logic                                 load,
   output logic [MATRIX_ROWS-1:0]               row,
   output logic [MATRIX_COLS-1:0]               col,
   output logic [ROW_W-1:0]                     scan_row,
   output logic                                 frame_start,
   output logic                                 busy
);

   localparam int FRAME_W = MATRIX_ROWS * MATRIX_COLS;
   localparam int DIV_W   = $clog2(SCAN_DIV);

   logic [DIV_W-1:0]   div_cnt;
   logic               row_tick;
   logic               swap;
   logic               blank;
   logic [MATRIX_ROWS-1:0] row_onehot;

   logic               start_q, start_d;
   logic [ROW_W-1:0]   row_idx_q, row_idx_d;
   logic [FRAME_W-1:0] pend_buf_q, pend_buf_d;
   logic               pend_valid_q, pend_valid_d;
   logic [FRAME_W-1:0] disp_buf_q, disp_buf_d;
   logic               frame_start_q, frame_start_d;

   // The first edge after reset release only arms start_q; the counters
   // hold there so that the following cycle (row 0, count 0) carries the
   // registered frame_start pulse like every later frame.
   scan_divider #(.SCAN_DIV(SCAN_DIV)) u_div (
      .clk     (clk),
      .reset   (reset),
      .en      (start_q),
      .div_cnt (div_cnt),
      .tick    (row_tick)
   );

   always_comb begin
      start_d       = 1'b1;
      row_idx_d     = row_idx_q;
      pend_buf_d    = pend_buf_q;
      pend_valid_d  = pend_valid_q;
      disp_buf_d    = disp_buf_q;

      if (row_tick) row_idx_d = row_idx_q + ROW_W'(1);
      swap = row_tick && (row_idx_q == ROW_W'(MATRIX_ROWS - 1));

      if (swap && pend_valid_q) begin
         disp_buf_d   = pend_buf_q;
         pend_valid_d = 1'b0;
      end

      // A load on the swap cycle bypasses the pending slot entirely so the
      // newest frame is shown from the very next row 0.
      if (load) begin
         if (swap) begin
            disp_buf_d   = matrix;
            pend_valid_d = 1'b0;
         end else begin
            pend_buf_d   = matrix;
            pend_valid_d = 1'b1;
         end
      end

      // Next cycle is row 0 / count 0: either a slot wrap into row 0, or the
      // held first cycle after reset.
      frame_start_d = (row_idx_d == '0) && (row_tick || !start_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         start_q       <= 1'b0;
         row_idx_q     <= '0;
         pend_buf_q    <= '0;
         pend_valid_q  <= 1'b0;
         disp_buf_q    <= '0;
         frame_start_q <= 1'b0;
      end else begin
         start_q       <= start_d;
         row_idx_q     <= row_idx_d;
         pend_buf_q    <= pend_buf_d;
         pend_valid_q  <= pend_valid_d;
         disp_buf_q    <= disp_buf_d;
         frame_start_q <= frame_start_d;
      end
   end

`ifdef MATRIX_BLANK_EN
   localparam logic [31:0] BLANK_U = 32'(BLANK_CYCLES);
   assign blank = (32'(div_cnt) < BLANK_U);
`else
   logic unused_cfg;
   assign blank      = 1'b0;
   assign unused_cfg = ^{div_cnt, 32'(BLANK_CYCLES)};
`endif

   always_comb begin
      row_onehot            = '0;
      row_onehot[row_idx_q] = 1'b1;
      row = blank ? '0 : row_onehot;
      col = blank ? '1 : ~disp_buf_q[pix(row_idx_q, '0) +: MATRIX_COLS];
   end

   assign scan_row    = row_idx_q;
   assign frame_start = frame_start_q;
   assign busy        = pend_valid_q;

endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan -- randomized and directed check of matrix_scan against a
// frame-level reference: the display at cycle t shows the most recent frame
// loaded before the start of t's frame; busy means a load landed earlier in
// the current frame. Works with and without MATRIX_BLANK_EN.
module tb_matrix_scan;

   localparam int SD = 4;
   localparam int BC = 1;
   localparam int FR = 8 * SD;

   typedef struct {
      int          cyc;
      logic [63:0] data;
   } load_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] matrix;
   logic        load;
   logic [7:0]  row;
   logic [7:0]  col;
   logic [2:0]  scan_row;
   logic        frame_start;
   logic        busy;

   int    n_vec = 0;
   int    n_err = 0;
   int    t     = 0;
   load_t loads[$];

`ifdef MATRIX_BLANK_EN
   localparam logic [7:0] ROW_RST = 8'h00;
`else
   localparam logic [7:0] ROW_RST = 8'h01;
`endif

   matrix_scan #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
      .clk         (clk),
      .reset       (reset),
      .matrix      (matrix),
      .load        (load),
      .row         (row),
      .col         (col),
      .scan_row    (scan_row),
      .frame_start (frame_start),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s t=%0d got=%h want=%h", tag, t, obs, exp);
      end
   endtask

   // frame shown during cycle t
   function automatic logic [63:0] disp_at(input int tc);
      logic [63:0] d = '0;
      int fs = (tc / FR) * FR;
      foreach (loads[i]) if (loads[i].cyc < fs) d = loads[i].data;
      return d;
   endfunction

   function automatic logic busy_at(input int tc);
      int fs = (tc / FR) * FR;
      foreach (loads[i]) if (loads[i].cyc >= fs && loads[i].cyc < tc) return 1'b1;
      return 1'b0;
   endfunction

   task automatic check_all();
      int          r     = (t / SD) % 8;
      logic        blank = 1'b0;
      logic [63:0] d     = disp_at(t);
      logic [7:0]  pix_row, e_row, e_col;
`ifdef MATRIX_BLANK_EN
      blank = (t % SD) < BC;
`endif
      pix_row = d[8*r +: 8];
      e_row   = blank ? 8'h00 : 8'(1 << r);
      e_col   = blank ? 8'hFF : ~pix_row;
      chk("row",         64'(row),         64'(e_row));
      chk("col",         64'(col),         64'(e_col));
      chk("scan_row",    64'(scan_row),    64'(r));
      chk("frame_start", 64'(frame_start), 64'(t % FR == 0));
      chk("busy",        64'(busy),        64'(busy_at(t)));
   endtask

   // drive one cycle (load decision for cycle t), then check cycle t+1
   task automatic step(input logic ld, input logic [63:0] d);
      load   = ld;
      matrix = d;
      if (ld) loads.push_back('{cyc: t, data: d});
      @(posedge clk);
      #1;
      load = 1'b0;
      t++;
      check_all();
   endtask

   task automatic go_to(input int phase);
      while (t % FR != phase) step(1'b0, '0);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_row"},  64'(row),         64'(ROW_RST));
      chk({tag, "_col"},  64'(col),         64'hFF);
      chk({tag, "_srow"}, 64'(scan_row),    64'h0);
      chk({tag, "_fs"},   64'(frame_start), 64'h0);
      chk({tag, "_busy"}, 64'(busy),        64'h0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      t = 0;
      loads.delete();
      check_all();
   endtask

   initial begin
      reset  = 1'b0;
      load   = 1'b0;
      matrix = '0;
      #3;
      check_reset_vals("rst0");
      repeat (3) @(posedge clk);
      #1;
      check_reset_vals("rst1");
      release_reset();

      // scan order with a diagonal
      step(1'b1, 64'h8040201008040201);
      repeat (2 * FR) step(1'b0, '0);

      // double buffering: load mid-frame at row 3
      go_to(3 * SD);
      step(1'b1, 64'h0000_0000_0000_00FF);
      repeat (FR + 4) step(1'b0, '0);

      // overwrite within one frame
      go_to(2);
      step(1'b1, 64'hAAAA_AAAA_AAAA_AAAA);
      repeat (9) step(1'b0, '0);
      step(1'b1, 64'h5555_5555_5555_5555);
      repeat (FR + 4) step(1'b0, '0);

      // swap-cycle load, idle and with a frame already pending
      go_to(FR - 1);
      step(1'b1, 64'h0000_0000_0000_0001);
      go_to(5);
      step(1'b1, 64'h1234_5678_9ABC_DEF0);
      go_to(FR - 1);
      step(1'b1, 64'h0F0F_0F0F_0F0F_0F0F);
      repeat (FR) step(1'b0, '0);

      // randomized loads
      for (int i = 0; i < 1500; i++) begin
         logic        ld = ($urandom_range(0, 7) == 0);
         logic [63:0] d  = {$urandom(), $urandom()};
         step(ld, d);
      end

      // reset mid-scan with a frame pending
      go_to(10);
      step(1'b1, 64'hDEAD_BEEF_CAFE_F00D);
      repeat (3) step(1'b0, '0);
      reset = 1'b0;
      #1;
      check_reset_vals("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("rst_hold");
      release_reset();
      repeat (2 * FR) step(1'b0, '0);
      for (int i = 0; i < 300; i++) begin
         logic        ld = ($urandom_range(0, 3) == 0);
         logic [63:0] d  = {$urandom(), $urandom()};
         step(ld, d);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
